vend_controller: RTL and testbench

Transaction controller for the vending machine datapath. Accumulates coin credit, checks a product selection against price and stock, sequences the dispense mechanism over a req/done handshake, then returns change as a paced pulse train to the coin hopper. Sits between the coin acceptor/keypad front end and the dispense motor and hopper drivers.

---
 rtl/vend_controller_if.sv | 33 +++
 rtl/vend_controller.sv | 173 +++++++++++++++++
 tb/tb_vend_controller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/vend_controller_if.sv
// Front-end / actuator signal bundle for vend_controller.
// i_* are driven toward the controller, o_* come back from it.
interface vend_controller_if #(
   parameter int CREDIT_W = 6
);
   logic [1:0]          i_coin;
   logic                i_sel_valid;
   logic [1:0]          i_sel;
   logic [3:0]          i_slot_empty;
   logic                i_cancel;
   logic                i_dispense_done;
   logic [CREDIT_W-1:0] o_credit;
   logic                o_dispense_req;
   logic [1:0]          o_dispense_slot;
   logic                o_change_pulse;
   logic                o_coin_reject;
   logic                o_sel_error;
   logic                o_z;
   logic                o_change_given;
   logic                o_busy;

   modport slave (
      input  i_coin, i_sel_valid, i_sel, i_slot_empty, i_cancel, i_dispense_done,
      output o_credit, o_dispense_req, o_dispense_slot, o_change_pulse,
             o_coin_reject, o_sel_error, o_z, o_change_given, o_busy
   );

   modport master (
      output i_coin, i_sel_valid, i_sel, i_slot_empty, i_cancel, i_dispense_done,
      input  o_credit, o_dispense_req, o_dispense_slot, o_change_pulse,
             o_coin_reject, o_sel_error, o_z, o_change_given, o_busy
   );
endinterface

// File: rtl/vend_controller.sv
// Vending transaction controller: coin credit, selection check, dispense
// handshake and paced change return. Every output is a register.
module vend_controller #(
   parameter int PRICE      = 15,
   parameter int MAX_CREDIT = 35,
   parameter int CREDIT_W   = 6,
   parameter int TIMEOUT    = 255
) (
   input  logic             clk,
   input  logic             rst,
   vend_controller_if.slave bus
);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [CREDIT_W-1:0] LP_PRICE = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] LP_FIVE  = CREDIT_W'(5);
   localparam logic [CREDIT_W-1:0] LP_TEN   = CREDIT_W'(10);
   localparam logic [CREDIT_W:0]   LP_MAX   = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [TMO_W-1:0]    LP_TLAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_CHANGE} state_t;

   state_t              r_state, w_state_nxt;
   logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
   logic [1:0]          r_slot, w_slot_nxt;
   logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
   logic                r_req, w_req_nxt;
   logic                r_cp, w_cp_nxt;
   logic                r_rej, w_rej_nxt;
   logic                r_serr, w_serr_nxt;
   logic                r_z, w_z_nxt;
   logic                r_cg, w_cg_nxt;
   logic                r_busy, w_busy_nxt;

   logic [CREDIT_W-1:0] w_coin_val;
   logic                w_coin_any;
   logic                w_coin_ok;
   logic [CREDIT_W:0]   w_sum;
   logic                w_sel_ok;

   always_comb begin
      w_coin_val = '0;
      case (bus.i_coin)
         2'b01:   w_coin_val = LP_FIVE;
         2'b10:   w_coin_val = LP_TEN;
         default: w_coin_val = '0;
      endcase
   end

   // Ceiling check is done one bit wider so the sum itself can never wrap.
   assign w_coin_any = (bus.i_coin != 2'b00);
   assign w_sum      = {1'b0, r_credit} + {1'b0, w_coin_val};
   assign w_coin_ok  = (bus.i_coin == 2'b01 || bus.i_coin == 2'b10) && (w_sum <= LP_MAX);
   assign w_sel_ok   = (r_credit >= LP_PRICE) && !bus.i_slot_empty[bus.i_sel];

   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_slot_nxt   = r_slot;
      w_tmo_nxt    = r_tmo;
      w_req_nxt    = 1'b0;
      w_cp_nxt     = 1'b0;
      w_rej_nxt    = 1'b0;
      w_serr_nxt   = 1'b0;
      w_z_nxt      = 1'b0;
      w_cg_nxt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_credit_nxt = '0;
            w_serr_nxt   = bus.i_sel_valid;
            if (w_coin_ok) begin
               w_credit_nxt = w_coin_val;
               w_tmo_nxt    = '0;
               w_state_nxt  = S_CREDIT;
            end else if (w_coin_any) begin
               w_rej_nxt = 1'b1;
            end
         end
         S_CREDIT: begin
            if (bus.i_cancel) begin
               w_rej_nxt   = w_coin_any;
               w_tmo_nxt   = '0;
               w_state_nxt = S_CHANGE;
            end else if (bus.i_sel_valid && w_sel_ok) begin
               w_rej_nxt    = w_coin_any;
               w_slot_nxt   = bus.i_sel;
               w_credit_nxt = r_credit - LP_PRICE;
               w_req_nxt    = 1'b1;
               w_tmo_nxt    = '0;
               w_state_nxt  = S_DISPENSE;
            end else if (bus.i_sel_valid || w_coin_any) begin
               // A refused selection still lets a same-cycle coin through.
               w_serr_nxt = bus.i_sel_valid;
               w_tmo_nxt  = '0;
               if (w_coin_ok)
                  w_credit_nxt = w_sum[CREDIT_W-1:0];
               else
                  w_rej_nxt = w_coin_any;
            end else if (r_tmo == LP_TLAST) begin
               w_tmo_nxt   = '0;
               w_state_nxt = S_CHANGE;
            end else begin
               w_tmo_nxt = r_tmo + TMO_W'(1);
            end
         end
         S_DISPENSE: begin
            w_rej_nxt  = w_coin_any;
            w_serr_nxt = bus.i_sel_valid;
            if (bus.i_dispense_done) begin
               w_z_nxt     = 1'b1;
               w_state_nxt = (r_credit != '0) ? S_CHANGE : S_IDLE;
            end else begin
               w_req_nxt = 1'b1;
            end
         end
         S_CHANGE: begin
            w_rej_nxt  = w_coin_any;
            w_serr_nxt = bus.i_sel_valid;
            // Pulse / gap alternation keyed off the registered pulse itself.
            if (r_cg) begin
               w_state_nxt = S_IDLE;
            end else if (r_cp) begin
               w_cg_nxt = (r_credit == '0);
            end else if (r_credit >= LP_FIVE) begin
               w_cp_nxt     = 1'b1;
               w_credit_nxt = r_credit - LP_FIVE;
            end else begin
               w_credit_nxt = '0;
               w_cg_nxt     = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt == S_DISPENSE) || (w_state_nxt == S_CHANGE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_credit <= '0;
         r_slot   <= '0;
         r_tmo    <= '0;
         r_req    <= 1'b0;
         r_cp     <= 1'b0;
         r_rej    <= 1'b0;
         r_serr   <= 1'b0;
         r_z      <= 1'b0;
         r_cg     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_credit <= w_credit_nxt;
         r_slot   <= w_slot_nxt;
         r_tmo    <= w_tmo_nxt;
         r_req    <= w_req_nxt;
         r_cp     <= w_cp_nxt;
         r_rej    <= w_rej_nxt;
         r_serr   <= w_serr_nxt;
         r_z      <= w_z_nxt;
         r_cg     <= w_cg_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign bus.o_credit        = r_credit;
   assign bus.o_dispense_req  = r_req;
   assign bus.o_dispense_slot = r_slot;
   assign bus.o_change_pulse  = r_cp;
   assign bus.o_coin_reject   = r_rej;
   assign bus.o_sel_error     = r_serr;
   assign bus.o_z             = r_z;
   assign bus.o_change_given  = r_cg;
   assign bus.o_busy          = r_busy;
endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller with hand-computed expectations.
module tb_vend_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_cp = 0;
   int   n_z = 0;
   int   cp0, z0;
   logic seen;

   vend_controller_if #(.CREDIT_W(6)) b ();

   vend_controller #(.PRICE(15), .MAX_CREDIT(35), .CREDIT_W(6), .TIMEOUT(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (b.o_change_pulse) n_cp++;
      if (b.o_z) n_z++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coin_in(input logic [1:0] c);
      b.i_coin = c;
      tick();
      b.i_coin = 2'b00;
   endtask

   task automatic sel_in(input logic [1:0] s);
      b.i_sel_valid = 1'b1;
      b.i_sel = s;
      tick();
      b.i_sel_valid = 1'b0;
   endtask

   function automatic logic [6:0] flags();
      return {b.o_dispense_req, b.o_change_pulse, b.o_coin_reject, b.o_sel_error,
              b.o_z, b.o_change_given, b.o_busy};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog got=0 exp=1");
      $fatal(1, "watchdog expired");
   end

   initial begin
      b.i_coin = 2'b00; b.i_sel_valid = 1'b0; b.i_sel = 2'b00;
      b.i_slot_empty = 4'b0000; b.i_cancel = 1'b0; b.i_dispense_done = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_credit", b.o_credit, 0);
      chk("rst_slot", b.o_dispense_slot, 0);
      chk("rst_flags", flags(), 0);

      // 5 + 10, vend slot 2, exact price
      cp0 = n_cp; z0 = n_z;
      coin_in(2'b01); chk("t1_cr5", b.o_credit, 5);
      coin_in(2'b10); chk("t1_cr15", b.o_credit, 15);
      sel_in(2'd2);
      chk("t1_req", b.o_dispense_req, 1);
      chk("t1_cr0", b.o_credit, 0);
      chk("t1_slot", b.o_dispense_slot, 2);
      chk("t1_busy", b.o_busy, 1);
      tick(); tick();
      chk("t1_req_hold", b.o_dispense_req, 1);
      b.i_dispense_done = 1'b1; tick(); b.i_dispense_done = 1'b0;
      chk("t1_req_drop", b.o_dispense_req, 0);
      chk("t1_z", b.o_z, 1);
      chk("t1_idle", b.o_busy, 0);
      tick(); tick();
      chk("t1_z_once", n_z - z0, 1);
      chk("t1_no_cp", n_cp - cp0, 0);

      // 10 + 10, vend slot 0, 5 change
      cp0 = n_cp;
      coin_in(2'b10); coin_in(2'b10); chk("t2_cr20", b.o_credit, 20);
      sel_in(2'd0); chk("t2_cr5", b.o_credit, 5);
      b.i_dispense_done = 1'b1; tick(); b.i_dispense_done = 1'b0;
      chk("t2_z", b.o_z, 1);
      chk("t2_busy", b.o_busy, 1);
      tick(); chk("t2_cp", b.o_change_pulse, 1); chk("t2_cr0", b.o_credit, 0);
      tick(); chk("t2_cg", {b.o_change_pulse, b.o_change_given}, 2'b01);
      tick(); chk("t2_idle", flags(), 0);
      chk("t2_cp_cnt", n_cp - cp0, 1);

      // ceiling reject then cancel refund of 30
      cp0 = n_cp;
      coin_in(2'b10); coin_in(2'b10); coin_in(2'b10);
      coin_in(2'b10);
      chk("t3_rej", b.o_coin_reject, 1);
      chk("t3_cr30", b.o_credit, 30);
      tick(); chk("t3_rej_1cyc", b.o_coin_reject, 0);
      b.i_cancel = 1'b1; tick(); b.i_cancel = 1'b0;
      chk("t3_busy", b.o_busy, 1);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("t3_cp_hi", b.o_change_pulse, 1);
         chk("t3_cr", b.o_credit, 30 - 5 * (k + 1));
         tick();
         chk("t3_cp_lo", {b.o_change_pulse, b.o_change_given}, (k == 5) ? 2'b01 : 2'b00);
      end
      tick(); chk("t3_idle", flags(), 0);
      chk("t3_cp_cnt", n_cp - cp0, 6);

      // selection refusals: short credit, empty slot, then good slot
      coin_in(2'b10);
      sel_in(2'd1);
      chk("t4_serr_credit", {b.o_sel_error, b.o_dispense_req}, 2'b10);
      chk("t4_cr10", b.o_credit, 10);
      coin_in(2'b01); chk("t4_cr15", b.o_credit, 15);
      b.i_slot_empty = 4'b0010;
      sel_in(2'd1);
      chk("t4_serr_empty", {b.o_sel_error, b.o_dispense_req}, 2'b10);
      sel_in(2'd3);
      chk("t4_req", {b.o_sel_error, b.o_dispense_req}, 2'b01);
      chk("t4_slot", b.o_dispense_slot, 3);
      b.i_slot_empty = 4'b0000;
      b.i_dispense_done = 1'b1; tick(); b.i_dispense_done = 1'b0;
      chk("t4_z_idle", {b.o_z, b.o_busy}, 2'b10);

      // inactivity timeout refund, then invalid coin in IDLE
      cp0 = n_cp;
      coin_in(2'b01);
      repeat (254) tick();
      chk("t5_pre_tmo", b.o_busy, 0);
      tick(); chk("t5_tmo", b.o_busy, 1);
      tick(); chk("t5_cp", b.o_change_pulse, 1);
      tick(); chk("t5_cg", b.o_change_given, 1);
      tick(); chk("t5_cp_cnt", n_cp - cp0, 1);
      coin_in(2'b11);
      chk("t5_rej11", b.o_coin_reject, 1);
      chk("t5_cr0", b.o_credit, 0);

      // reset during dispense, then cancel with simultaneous coin
      tick();
      coin_in(2'b10); coin_in(2'b01); sel_in(2'd0);
      chk("t6_req", b.o_dispense_req, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t6_rst_flags", flags(), 0);
      chk("t6_rst_cr", b.o_credit, 0);
      cp0 = n_cp;
      coin_in(2'b10);
      b.i_cancel = 1'b1; b.i_coin = 2'b01; tick();
      b.i_cancel = 1'b0; b.i_coin = 2'b00;
      chk("t6_rej", b.o_coin_reject, 1);
      chk("t6_cr10", b.o_credit, 10);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (b.o_change_given) seen = 1'b1;
      end
      chk("t6_cg_seen", seen, 1);
      chk("t6_cp_cnt", n_cp - cp0, 2);
      chk("t6_cr_end", b.o_credit, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
